// File: rtl/fetch_queue_unit_if.sv
// Fetch-stage bundle: instruction memory read port plus the decode/execute side
// controls and the queue-head view delivered to decode.
interface fetch_queue_unit_if #(
   parameter int IMEM_AW = 10
);
   logic                imem_req;
   logic [IMEM_AW-1:0]  imem_addr;
   logic [31:0]         imem_rdata;
   logic                bubble;
   logic                redirect_en;
   logic [31:0]         redirect_pc;
   logic                halt;
   logic                resume;
   logic                if_valid;
   logic [31:0]         if_inst;
   logic [31:0]         if_pc;
   logic [31:0]         if_pc4;

   modport master (
      output imem_req, imem_addr, if_valid, if_inst, if_pc, if_pc4,
      input  imem_rdata, bubble, redirect_en, redirect_pc, halt, resume
   );

   modport slave (
      input  imem_req, imem_addr, if_valid, if_inst, if_pc, if_pc4,
      output imem_rdata, bubble, redirect_en, redirect_pc, halt, resume
   );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch: owns the PC, reads a synchronous imem and queues results for decode.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_stall counters.
//
// state   | meaning
// RUN     | issuing sequential fetches while the queue has room
// HALTED  | no new issue; inflight response and queued entries still drain
module fetch_queue_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          QDEPTH   = 2,
   parameter int          IMEM_AW  = 10
) (
   input  logic clk,
   input  logic rst_n,
   fetch_queue_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall
`endif
);
   localparam int PW = (QDEPTH > 2) ? 2 : 1;
   localparam int CW = $clog2(QDEPTH + 1);
   localparam logic [CW:0]   QD       = (CW + 1)'(QDEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(QDEPTH - 1);

   typedef enum logic {ST_RUN, ST_HALTED} state_t;

   state_t          state_q, state_d;
   logic [31:0]     pc_q, req_pc_q;
   logic            inflight_q, tag_q, epoch_q;
   logic [PW-1:0]   head_q, tail_q, view_q;
   logic [CW-1:0]   count_q, count_d;
   logic [31:0]     inst_q    [QDEPTH];
   logic [31:0]     ent_pc_q  [QDEPTH];
   logic [31:0]     ent_pc4_q [QDEPTH];
   logic [CW:0]     occ;
   logic            if_valid, consume, resp_ok, issue;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   assign if_valid = (count_q != '0);
   assign consume  = if_valid & ~bus.bubble & ~bus.redirect_en;
   assign resp_ok  = inflight_q & (tag_q == epoch_q) & ~bus.redirect_en;
   assign occ      = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};

   always_comb begin
      count_d = count_q;
      case ({resp_ok, consume})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_RUN;
      else        state_q <= state_d;
   end

   // halt is only seen by the state register, so the halt cycle itself may still issue
   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      case (state_q)
         ST_RUN: begin
            issue = ~bus.redirect_en & ((occ < QD) | consume);
            if (bus.halt) state_d = ST_HALTED;
         end
         ST_HALTED: begin
            if (bus.resume && !bus.halt) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
         tag_q      <= 1'b0;
         epoch_q    <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
         view_q     <= '0;
         count_q    <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            inst_q[i]    <= '0;
            ent_pc_q[i]  <= '0;
            ent_pc4_q[i] <= '0;
         end
      end else if (bus.redirect_en) begin
         pc_q       <= bus.redirect_pc & ~32'h3;
         epoch_q    <= ~epoch_q;
         inflight_q <= 1'b0;
         count_q    <= '0;
         tail_q     <= head_q;
      end else begin
         inflight_q <= issue;
         if (issue) begin
            pc_q     <= pc_q + 32'd4;
            req_pc_q <= pc_q;
            tag_q    <= epoch_q;
         end
         if (resp_ok) begin
            inst_q[tail_q]    <= bus.imem_rdata;
            ent_pc_q[tail_q]  <= req_pc_q;
            ent_pc4_q[tail_q] <= req_pc_q + 32'd4;
            tail_q            <= ptr_inc(tail_q);
         end
         if (consume) head_q <= ptr_inc(head_q);
         count_q <= count_d;
         // view follows the head while entries exist, else keeps the last one shown
         if (count_d != '0) view_q <= consume ? ptr_inc(head_q) : head_q;
      end
   end

   assign bus.imem_req  = issue & rst_n;
   assign bus.imem_addr = pc_q[IMEM_AW+1:2];
   assign bus.if_valid  = if_valid;
   assign bus.if_inst   = inst_q[view_q];
   assign bus.if_pc     = ent_pc_q[view_q];
   assign bus.if_pc4    = ent_pc4_q[view_q];

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (resp_ok)              perf_fetched <= perf_fetched + 32'd1;
         if (if_valid & bus.bubble) perf_stall  <= perf_stall + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit against a queue-level model of the fetch stage.
module tb_fetch_queue_unit;
   localparam int          AW     = 12;
   localparam int          QDEPTH = 2;
   localparam logic [31:0] RST_PC = 32'h0000_3000;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   fetch_queue_unit_if #(.IMEM_AW(AW)) bus ();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_stall;
`endif

   fetch_queue_unit #(.RESET_PC(RST_PC), .QDEPTH(QDEPTH), .IMEM_AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_stall   (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      return {~a[7:0], 8'h5A, 4'hE, a};
   endfunction

   always @(posedge clk) begin
      if (bus.imem_req) bus.imem_rdata <= mem_word(bus.imem_addr);
   end

   // reference model state
   ent_t        mq[$];
   logic [31:0] m_pc, m_pend_pc, m_disp_inst, m_disp_pc, m_disp_pc4;
   bit          m_pend, m_halted;
   int unsigned m_fetched, m_stall;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc        = RST_PC;
      m_pend      = 0;
      m_pend_pc   = '0;
      m_halted    = 0;
      m_disp_inst = '0;
      m_disp_pc   = '0;
      m_disp_pc4  = '0;
      m_fetched   = 0;
      m_stall     = 0;
   endtask

   // one clock cycle: apply inputs, compare outputs with the model, advance the model
   task automatic step(input logic b, input logic r, input logic [31:0] rp,
                       input logic h, input logic rs);
      bit m_cons, m_req;
      bus.bubble      = b;
      bus.redirect_en = r;
      bus.redirect_pc = rp;
      bus.halt        = h;
      bus.resume      = rs;
      #1;
      m_cons = (mq.size() != 0) && !b && !r;
      m_req  = !m_halted && !r && (((mq.size() + int'(m_pend)) < QDEPTH) || m_cons);
      chk("if_valid", 32'(bus.if_valid), 32'(mq.size() != 0));
      chk("if_inst", bus.if_inst, m_disp_inst);
      chk("if_pc", bus.if_pc, m_disp_pc);
      chk("if_pc4", bus.if_pc4, m_disp_pc4);
      chk("imem_req", 32'(bus.imem_req), 32'(m_req));
      if (m_req) chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc[AW+1:2]));
      if (mq.size() != 0 && b) m_stall++;
      if (r) begin
         mq.delete();
         m_pend = 0;
         m_pc   = rp & ~32'h3;
      end else begin
         if (m_pend) begin
            mq.push_back('{inst: mem_word(m_pend_pc[AW+1:2]), pc: m_pend_pc});
            m_fetched++;
         end
         if (m_cons) void'(mq.pop_front());
         m_pend = m_req;
         if (m_req) begin
            m_pend_pc = m_pc;
            m_pc      = m_pc + 32'd4;
         end
      end
      chk("no_overflow", 32'(mq.size() <= QDEPTH), 32'd1);
      if (h)       m_halted = 1;
      else if (rs) m_halted = 0;
      if (mq.size() != 0) begin
         m_disp_inst = mq[0].inst;
         m_disp_pc   = mq[0].pc;
         m_disp_pc4  = mq[0].pc + 32'd4;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic release_reset();
      rst_n = 1'b1;
      #1;
      chk("first_req", 32'(bus.imem_req), 32'd1);
      chk("first_addr", 32'(bus.imem_addr), 32'h0000_0C00);
   endtask

   initial begin
      bit seen;
      bus.bubble      = 1'b0;
      bus.redirect_en = 1'b0;
      bus.redirect_pc = '0;
      bus.halt        = 1'b0;
      bus.resume      = 1'b0;
      bus.imem_rdata  = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(bus.if_valid), 32'd0);
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_pc4", bus.if_pc4, 32'd0);

      // startup latency and streaming
      release_reset();
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("lat_valid", 32'(bus.if_valid), 32'd1);
      chk("lat_pc", bus.if_pc, 32'h3000);
      chk("lat_pc4", bus.if_pc4, 32'h3004);
      step(0, 0, 0, 0, 0);
      chk("stream_pc", bus.if_pc, 32'h3004);
      repeat (4) step(0, 0, 0, 0, 0);

      // stall until the queue fills, then continue
      repeat (5) step(1, 0, 0, 0, 0);
      chk("full_noreq", 32'(bus.imem_req), 32'd0);
      repeat (4) step(0, 0, 0, 0, 0);

      // redirect with the queue holding an entry and a response inflight
      repeat (2) step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 1, 32'h0000_3100, 0, 0);
      seen = 0;
      for (int i = 0; i < 6 && !seen; i++) begin
         if (bus.if_valid) seen = 1;
         else step(0, 0, 0, 0, 0);
      end
      chk("redir_seen", 32'(seen), 32'd1);
      chk("redir_pc0", bus.if_pc, 32'h3100);
      step(0, 0, 0, 0, 0);
      chk("redir_pc1", bus.if_pc, 32'h3104);

      // halt, drain, resume
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) begin
         chk("halt_noreq", 32'(bus.imem_req), 32'd0);
         step(0, 0, 0, 0, 0);
      end
      chk("halt_drained", 32'(bus.if_valid), 32'd0);
      step(0, 0, 0, 0, 1);
      chk("resume_req", 32'(bus.imem_req), 32'd1);
      chk("resume_addr", 32'(bus.imem_addr), 32'(m_disp_pc4[AW+1:2]));
      repeat (4) step(0, 0, 0, 0, 0);

      // asynchronous reset while full
      repeat (4) step(1, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.if_valid), 32'd0);
      chk("arst_req", 32'(bus.imem_req), 32'd0);
      chk("arst_pc", bus.if_pc, 32'd0);
      chk("arst_inst", bus.if_inst, 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      release_reset();
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("arst_restart", bus.if_pc, 32'h3000);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] rp;
         rp = 32'h3000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
         step(($urandom_range(0, 99) < 30),
              ($urandom_range(0, 99) < 5),
              rp,
              ($urandom_range(0, 99) < 3),
              ($urandom_range(0, 99) < 20));
      end

`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_stall", perf_stall, m_stall);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
